// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into the MSB
// so callers can derive two's-complement overflow.
module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic carry_s;

  // Ripple from LSB to MSB; cmsb_o keeps the carry seen by the last bit.
  always_comb begin
    carry_s = cin_i;
    cmsb_o  = 1'b0;
    sum_o   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cmsb_o   = carry_s;
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry_s;
      carry_s  = (a_i[i] & b_i[i]) | (carry_s & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry_s;
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock.
// Define CHUNKED_ADDER_OVERFLOW_EN to add the signed-overflow output.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNKED_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [CHUNK-1:0] chunk_sum_s;
  logic             chunk_cout_s;
  logic [WIDTH-1:0] res_shift_s;

`ifdef CHUNKED_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic chunk_cmsb_s;
`endif

  chunk_ripple_adder #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a_i   (sa_q[CHUNK-1:0]),
    .b_i   (sb_q[CHUNK-1:0]),
    .cin_i (carry_q),
    .sum_o (chunk_sum_s),
    .cout_o(chunk_cout_s),
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    .cmsb_o(chunk_cmsb_s)
`else
    .cmsb_o()
`endif
  );

  // New chunk enters at the MSB end so the LSB chunk lands in place after NCHUNK shifts.
  assign res_shift_s = (res_q >> CHUNK) | (WIDTH'(chunk_sum_s) << (WIDTH - CHUNK));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d    = sa_q >> CHUNK;
        sb_d    = sb_q >> CHUNK;
        res_d   = res_shift_s;
        carry_d = chunk_cout_s;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = res_shift_s;
          cout_d  = chunk_cout_s;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
          ovf_d   = chunk_cmsb_s ^ chunk_cout_s;
`endif
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the fixed 4-bit NAND ripple adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock through one small ripple-carry slice, with a registered carry between chunks.
- Uses valid/ready handshakes on both sides, so it drops into datapaths where area matters more than single-cycle latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0 = A+B+cin, 1 = A-B-cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry-out of final chunk. In subtract mode 1 = no borrow.

Behaviour:
- Reset (async): state = IDLE, in_ready=1, out_valid=0, sum=0, cout=0, chunk counter=0, carry register=0.
- NCHUNK = WIDTH/CHUNK.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture a into shift register SA; capture (sub ? ~b : b) into SB; carry = cin ^ sub; counter=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: add SA[CHUNK-1:0] + SB[CHUNK-1:0] + carry.
  - Shift the result chunk into the MSB end of the result register; shift SA/SB right by CHUNK; carry <= chunk carry-out; counter++.
  - On the cycle counter == NCHUNK-1: load final sum and cout, go to DONE.
- DONE:
  - out_valid=1; sum/cout held stable.
  - On out_ready: out_valid drops next cycle, go to IDLE.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. For CHUNK=WIDTH this is 1 cycle.
- Throughput: one operation per NCHUNK+2 cycles minimum. There is no overlap: in_ready=0 in RUN and DONE.
- Operands changing during RUN/DONE are ignored.
- sum and cout update only on the transition into DONE; they hold their last value in IDLE.
- in_valid without in_ready has no effect. out_ready outside DONE has no effect.
- Wrap-around: results are modulo 2^WIDTH; cout reports the carry.
- rst asserted mid-RUN or mid-DONE aborts the operation; all outputs return to reset values immediately.

Optional Feature:
- Macro: CHUNKED_ADDER_OVERFLOW_EN.
- When defined: adds output port `overflow` (1 bit, reset 0) = two's-complement signed overflow.
  - Computed in the final chunk as carry-into-MSB XOR carry-out-of-MSB.
  - Registered alongside sum and held identically.
- When undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package `adder_pkg`: state enum {IDLE, RUN, DONE}; localparam helper for NCHUNK; counter width = $clog2(NCHUNK) (minimum 1).
- One sub-module: `chunk_ripple_adder`.
  - Combinational CHUNK-bit ripple of full adders.
  - Outputs: sum chunk, carry-out, carry into MSB (for overflow).
  - Reused by later wide adders.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- a=0x0001, b=0x0002, cin=0, sub=0 accepted -> out_valid exactly 4 cycles later, sum=0x0003, cout=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1 (carry ripples across all chunks).
- a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0 (borrow). a=0x0007, b=0x0005, cin=1, sub=1 -> sum=0x0001, cout=1.
- Back-pressure: out_ready held low 3 cycles after out_valid -> sum/cout stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle; in_valid held high during RUN is not accepted.
- Reset mid-RUN after 2 chunks -> out_valid=0, sum=0, cout=0, in_ready=1 immediately; a new operation then completes correctly.
- With CHUNKED_ADDER_OVERFLOW_EN: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, overflow=1, cout=0. Repeat with CHUNK=16 -> latency 1, same result.
